// File: rtl/player_grid_mover.sv
// Purpose : owns one player's grid position and facing; turns frame-rate buttons into checked single-tile moves.
// Latency : turn and tile_req are registered 1 cycle after the acting frame_tick; move lands 1 cycle after tile_valid.
// Backpressure: none upstream; waits up to LOOKUP_TIMEOUT cycles for tile_valid, then MOVE_COOLDOWN frames before the next move.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   frame_tick, freeze        per-frame pulse; pause (blocks new moves/turns)
//   btn_left/right/up/down    debounced levels, priority L > R > U > D
//   tile_req, tile_x, tile_y  one-cycle lookup request and its target tile
//   tile_valid, tile_blocked  lookup response
//   grid_x, grid_y            current position
//   player_direction          LEFT=0 RIGHT=1 UP=2 DOWN=3
//   moved                     one-cycle pulse aligned with the new position
//   busy                      high whenever not IDLE
module player_grid_mover #(
    parameter int GRID_W         = 12,
    parameter int GRID_H         = 8,
    parameter int START_X        = 1,
    parameter int START_Y        = 1,
    parameter int MOVE_COOLDOWN  = 8,
    parameter int LOOKUP_TIMEOUT = 15
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       tile_req,
    output logic [3:0] tile_x,
    output logic [2:0] tile_y,
    input  logic       tile_valid,
    input  logic       tile_blocked,
    output logic [3:0] grid_x,
    output logic [2:0] grid_y,
    output logic [1:0] player_direction,
    output logic       moved,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOOKUP   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [3:0] X_MAX   = 4'(GRID_W - 1);
    localparam logic [2:0] Y_MAX   = 3'(GRID_H - 1);
    localparam logic [3:0] X_START = 4'(START_X);
    localparam logic [2:0] Y_START = 3'(START_Y);
    localparam logic [7:0] TO_LOAD = 8'(LOOKUP_TIMEOUT);
    localparam logic [7:0] CD_LOAD = 8'(MOVE_COOLDOWN);

    logic [1:0] state_q, state_d;
    logic [3:0] grid_x_q, grid_x_d;
    logic [2:0] grid_y_q, grid_y_d;
    logic [1:0] dir_q, dir_d;
    logic       tile_req_q, tile_req_d;
    logic [3:0] tile_x_q, tile_x_d;
    logic [2:0] tile_y_q, tile_y_d;
    logic       moved_q, moved_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] cool_q, cool_d;

    logic       any_btn;
    logic       act;
    logic [1:0] dir_sel;
    logic       at_edge;
    logic [3:0] tgt_x;
    logic [2:0] tgt_y;

    // Button decode and target; the edge check guarantees the +/-1 below never wraps.
    always_comb begin
        any_btn = btn_left | btn_right | btn_up | btn_down;
        act     = frame_tick & ~freeze & any_btn;
        dir_sel = DIR_DOWN;
        tgt_x   = grid_x_q;
        tgt_y   = grid_y_q;
        at_edge = 1'b0;
        if (btn_left) begin
            dir_sel = DIR_LEFT;
            at_edge = (grid_x_q == 4'd0);
            tgt_x   = grid_x_q - 4'd1;
        end else if (btn_right) begin
            dir_sel = DIR_RIGHT;
            at_edge = (grid_x_q == X_MAX);
            tgt_x   = grid_x_q + 4'd1;
        end else if (btn_up) begin
            dir_sel = DIR_UP;
            at_edge = (grid_y_q == 3'd0);
            tgt_y   = grid_y_q - 3'd1;
        end else begin
            dir_sel = DIR_DOWN;
            at_edge = (grid_y_q == Y_MAX);
            tgt_y   = grid_y_q + 3'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grid_x_d   = grid_x_q;
        grid_y_d   = grid_y_q;
        dir_d      = dir_q;
        tile_req_d = 1'b0;
        tile_x_d   = tile_x_q;
        tile_y_d   = tile_y_q;
        moved_d    = 1'b0;
        timer_d    = timer_q;
        cool_d     = cool_q;
        case (state_q)
            ST_IDLE: begin
                if (act) begin
                    // The turn sticks even if the lookup later fails.
                    dir_d = dir_sel;
                    if (!at_edge) begin
                        tile_x_d   = tgt_x;
                        tile_y_d   = tgt_y;
                        tile_req_d = 1'b1;
                        timer_d    = TO_LOAD;
                        state_d    = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                // timer_q counts down from the tile_req cycle, so a response on the
                // LOOKUP_TIMEOUT-th cycle after the request is still accepted.
                if (tile_valid) begin
                    if (!tile_blocked) begin
                        grid_x_d = tile_x_q;
                        grid_y_d = tile_y_q;
                        moved_d  = 1'b1;
                        cool_d   = CD_LOAD;
                        state_d  = (CD_LOAD == 8'd0) ? ST_IDLE : ST_COOLDOWN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timer_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_COOLDOWN: begin
                // Returning to IDLE here means the emptying tick cannot also start a move.
                if (frame_tick) begin
                    cool_d = cool_q - 8'd1;
                    if (cool_q <= 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            grid_x_q   <= X_START;
            grid_y_q   <= Y_START;
            dir_q      <= DIR_DOWN;
            tile_req_q <= 1'b0;
            tile_x_q   <= 4'd0;
            tile_y_q   <= 3'd0;
            moved_q    <= 1'b0;
            timer_q    <= 8'd0;
            cool_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            grid_x_q   <= grid_x_d;
            grid_y_q   <= grid_y_d;
            dir_q      <= dir_d;
            tile_req_q <= tile_req_d;
            tile_x_q   <= tile_x_d;
            tile_y_q   <= tile_y_d;
            moved_q    <= moved_d;
            timer_q    <= timer_d;
            cool_q     <= cool_d;
        end
    end

    assign tile_req         = tile_req_q;
    assign tile_x           = tile_x_q;
    assign tile_y           = tile_y_q;
    assign grid_x           = grid_x_q;
    assign grid_y           = grid_y_q;
    assign player_direction = dir_q;
    assign moved            = moved_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_grid_mover.sv
module tb_player_grid_mover;

    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic       frame_tick = 1'b0;
    logic       freeze = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       tile_req;
    logic [3:0] tile_x;
    logic [2:0] tile_y;
    logic       tile_valid = 1'b0;
    logic       tile_blocked = 1'b0;
    logic [3:0] grid_x;
    logic [2:0] grid_y;
    logic [1:0] player_direction;
    logic       moved;
    logic       busy;

    localparam logic [3:0] BL = 4'b0001;
    localparam logic [3:0] BR = 4'b0010;
    localparam logic [3:0] BU = 4'b0100;
    localparam logic [3:0] BD = 4'b1000;

    int errors = 0;
    int checks = 0;
    int px = 1;
    int py = 1;

    logic [6:0] exp_req_q[$];
    logic [6:0] exp_mv_q[$];
    logic [6:0] e_req;
    logic [6:0] e_mv;

    player_grid_mover dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .frame_tick(frame_tick),
        .freeze(freeze),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .tile_req(tile_req),
        .tile_x(tile_x),
        .tile_y(tile_y),
        .tile_valid(tile_valid),
        .tile_blocked(tile_blocked),
        .grid_x(grid_x),
        .grid_y(grid_y),
        .player_direction(player_direction),
        .moved(moved),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every tile_req and moved pulse must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_in) begin
            if (tile_req === 1'b1) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_tile_req: unexpected tile_req to (%0d,%0d), required none", tile_x, tile_y);
                end else begin
                    e_req = exp_req_q.pop_front();
                    if ({tile_x, tile_y} !== e_req) begin
                        errors++;
                        $display("FAIL sb_tile_xy: got (%0d,%0d) required (%0d,%0d)", tile_x, tile_y, e_req[6:3], e_req[2:0]);
                    end
                end
            end
            if (moved === 1'b1) begin
                checks++;
                if (exp_mv_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_moved: unexpected moved to (%0d,%0d), required none", grid_x, grid_y);
                end else begin
                    e_mv = exp_mv_q.pop_front();
                    if ({grid_x, grid_y} !== e_mv) begin
                        errors++;
                        $display("FAIL sb_move_xy: got (%0d,%0d) required (%0d,%0d)", grid_x, grid_y, e_mv[6:3], e_mv[2:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish within 100000 time units");
        $fatal(1);
    end

    // One frame with the given buttons; returns on the negedge where tile_req would show.
    task automatic press(input logic [3:0] b, input logic frz);
        @(negedge clk);
        frame_tick = 1'b1;
        freeze     = frz;
        {btn_down, btn_up, btn_right, btn_left} = b;
        @(negedge clk);
        frame_tick = 1'b0;
        freeze     = 1'b0;
        {btn_down, btn_up, btn_right, btn_left} = 4'b0000;
    endtask

    task automatic do_move(input logic [1:0] d);
        int nx;
        int ny;
        nx = px;
        ny = py;
        case (d)
            2'd0: nx = nx - 1;
            2'd1: nx = nx + 1;
            2'd2: ny = ny - 1;
            default: ny = ny + 1;
        endcase
        exp_req_q.push_back({4'(nx), 3'(ny)});
        press(BL << d, 1'b0);
        checks++;
        if (player_direction !== d) begin
            errors++;
            $display("FAIL move_dir: got %0d required %0d", player_direction, d);
        end
        @(negedge clk);
        tile_valid   = 1'b1;
        tile_blocked = 1'b0;
        exp_mv_q.push_back({4'(nx), 3'(ny)});
        @(negedge clk);
        tile_valid = 1'b0;
        px = nx;
        py = ny;
        checks++;
        if ({grid_x, grid_y} !== {4'(px), 3'(py)}) begin
            errors++;
            $display("FAIL move_grid: got (%0d,%0d) required (%0d,%0d)", grid_x, grid_y, px, py);
        end
        repeat (8) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL move_cooldown_end: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset;
        #3 rst_in = 1'b1;
        #1;
        checks++;
        if ({grid_x, grid_y} !== {4'd1, 3'd1}) begin
            errors++;
            $display("FAIL reset_grid: got (%0d,%0d) required (1,1)", grid_x, grid_y);
        end
        checks++;
        if (player_direction !== 2'd3) begin
            errors++;
            $display("FAIL reset_dir: got %0d required 3", player_direction);
        end
        checks++;
        if ({tile_req, busy, moved, tile_x, tile_y} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outs: req=%0b busy=%0b moved=%0b tile=(%0d,%0d) required all 0",
                     tile_req, busy, moved, tile_x, tile_y);
        end
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic test_free_move;
        exp_req_q.push_back({4'd2, 3'd1});
        press(BR, 1'b0);
        checks++;
        if ({tile_req, tile_x, tile_y, player_direction, busy} !== {1'b1, 4'd2, 3'd1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL free_req: req=%0b tile=(%0d,%0d) dir=%0d busy=%0b required 1,(2,1),1,1",
                     tile_req, tile_x, tile_y, player_direction, busy);
        end
        @(negedge clk);
        @(negedge clk);
        tile_valid   = 1'b1;
        tile_blocked = 1'b0;
        exp_mv_q.push_back({4'd2, 3'd1});
        @(negedge clk);
        tile_valid = 1'b0;
        checks++;
        if ({grid_x, grid_y, moved} !== {4'd2, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL free_grid: got (%0d,%0d) moved=%0b required (2,1) moved=1", grid_x, grid_y, moved);
        end
        px = 2;
        @(negedge clk);
        checks++;
        if (moved !== 1'b0) begin
            errors++;
            $display("FAIL free_moved_pulse: moved=%0b required 0", moved);
        end
        btn_right = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            checks++;
            if (tile_req !== 1'b0) begin
                errors++;
                $display("FAIL cooldown_tick%0d: tile_req=%0b required 0", i + 1, tile_req);
            end
        end
        exp_req_q.push_back({4'd3, 3'd1});
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        btn_right  = 1'b0;
        checks++;
        if (tile_req !== 1'b1) begin
            errors++;
            $display("FAIL cooldown_ninth: tile_req=%0b required 1", tile_req);
        end
        @(negedge clk);
        tile_valid   = 1'b1;
        tile_blocked = 1'b1;
        @(negedge clk);
        tile_valid   = 1'b0;
        tile_blocked = 1'b0;
        checks++;
        if ({busy, grid_x, grid_y} !== {1'b0, 4'd2, 3'd1}) begin
            errors++;
            $display("FAIL ninth_blocked: busy=%0b grid=(%0d,%0d) required 0,(2,1)", busy, grid_x, grid_y);
        end
    endtask

    task automatic test_blocked;
        exp_req_q.push_back({4'd2, 3'd0});
        press(BU, 1'b0);
        checks++;
        if (player_direction !== 2'd2) begin
            errors++;
            $display("FAIL blocked_dir: got %0d required 2", player_direction);
        end
        @(negedge clk);
        tile_valid   = 1'b1;
        tile_blocked = 1'b1;
        @(negedge clk);
        tile_valid   = 1'b0;
        tile_blocked = 1'b0;
        checks++;
        if ({grid_x, grid_y, moved, busy} !== {4'd2, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL blocked_state: grid=(%0d,%0d) moved=%0b busy=%0b required (2,1),0,0",
                     grid_x, grid_y, moved, busy);
        end
    endtask

    task automatic test_edge;
        do_move(2'd0);
        do_move(2'd0);
        do_move(2'd3);
        do_move(2'd3);
        press(BL, 1'b0);
        checks++;
        if ({player_direction, tile_req, busy, grid_x, grid_y} !== {2'd0, 1'b0, 1'b0, 4'd0, 3'd3}) begin
            errors++;
            $display("FAIL edge_left: dir=%0d req=%0b busy=%0b grid=(%0d,%0d) required 0,0,0,(0,3)",
                     player_direction, tile_req, busy, grid_x, grid_y);
        end
        for (int i = 0; i < 11; i++) do_move(2'd1);
        for (int i = 0; i < 4; i++) do_move(2'd3);
        press(BR, 1'b0);
        checks++;
        if ({player_direction, tile_req, busy} !== {2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL edge_right: dir=%0d req=%0b busy=%0b required 1,0,0", player_direction, tile_req, busy);
        end
        press(BD, 1'b0);
        checks++;
        if ({player_direction, tile_req, grid_x, grid_y} !== {2'd3, 1'b0, 4'd11, 3'd7}) begin
            errors++;
            $display("FAIL edge_down: dir=%0d req=%0b grid=(%0d,%0d) required 3,0,(11,7)",
                     player_direction, tile_req, grid_x, grid_y);
        end
    endtask

    task automatic test_priority_freeze;
        exp_req_q.push_back({4'd10, 3'd7});
        press(BL | BU, 1'b0);
        checks++;
        if (player_direction !== 2'd0) begin
            errors++;
            $display("FAIL prio_dir: got %0d required 0", player_direction);
        end
        @(negedge clk);
        tile_valid   = 1'b1;
        tile_blocked = 1'b1;
        @(negedge clk);
        tile_valid   = 1'b0;
        tile_blocked = 1'b0;
        press(BR | BD, 1'b1);
        checks++;
        if ({player_direction, tile_req, busy} !== {2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL freeze: dir=%0d req=%0b busy=%0b required 0,0,0", player_direction, tile_req, busy);
        end
    endtask

    task automatic test_timeout;
        exp_req_q.push_back({4'd10, 3'd7});
        press(BL, 1'b0);
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_last_wait: busy=%0b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_exit: busy=%0b required 0", busy);
        end
        tile_valid = 1'b1;
        @(negedge clk);
        tile_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({grid_x, grid_y, moved, busy} !== {4'd11, 3'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_late_valid: grid=(%0d,%0d) moved=%0b busy=%0b required (11,7),0,0",
                     grid_x, grid_y, moved, busy);
        end
    endtask

    task automatic test_reset_mid_lookup;
        exp_req_q.push_back({4'd10, 3'd7});
        press(BL, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: busy=%0b required 1", busy);
        end
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        checks++;
        if ({grid_x, grid_y, player_direction, busy, tile_req} !== {4'd1, 3'd1, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_state: grid=(%0d,%0d) dir=%0d busy=%0b req=%0b required (1,1),3,0,0",
                     grid_x, grid_y, player_direction, busy, tile_req);
        end
        @(negedge clk);
        rst_in     = 1'b0;
        tile_valid = 1'b1;
        @(negedge clk);
        tile_valid = 1'b0;
        checks++;
        if ({grid_x, grid_y, moved, busy} !== {4'd1, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_late_valid: grid=(%0d,%0d) moved=%0b busy=%0b required (1,1),0,0",
                     grid_x, grid_y, moved, busy);
        end
    endtask

    initial begin
        test_reset();
        test_free_move();
        test_blocked();
        test_edge();
        test_priority_freeze();
        test_timeout();
        test_reset_mid_lookup();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_req_q.size() != 0) begin
            errors++;
            $display("FAIL sb_req_drain: %0d lookups outstanding, required 0", exp_req_q.size());
        end
        checks++;
        if (exp_mv_q.size() != 0) begin
            errors++;
            $display("FAIL sb_move_drain: %0d moves outstanding, required 0", exp_mv_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
